// File: rtl/g07_slave_mem.sv
// g07_slave_mem: bus slave endpoint behind one arbiter slave port.
// Decodes a 20-bit address window, runs a fixed number of wait states,
// then completes a read or write on a local 64-bit word memory with a
// single-cycle Tdone. A HOLD state keeps a level-held en from retriggering.
module g07_slave_mem #(
  parameter logic [19:0] BASE_ADDR = 20'he7637,
  parameter int          DEPTH     = 256,
  parameter int          WAIT_CYC  = 2,
  parameter logic [63:0] ERR_DATA  = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic        sysClk,
  input  logic        Breset,
  input  logic        en,
  input  logic [63:0] addr,
  input  logic [63:0] SbusIn,
  output logic        Tdone,
  output logic [63:0] dbus_out,
  output logic        err
);

  localparam int AW        = $clog2(DEPTH);
  localparam bit ZERO_WAIT = (WAIT_CYC == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t        r_state;
  logic [3:0]    r_wcnt;
  logic          r_wr;
  logic [AW-1:0] r_idx;
  logic          r_inwin;
  logic [63:0]   r_data;
  logic          r_tdone;
  logic          r_err;
  logic [63:0]   r_dbus;
  logic [63:0]   r_mem [DEPTH];

  logic [19:0]   w_off;
  logic          w_inwin_now;
  logic          w_accept;
  logic          w_go_done;
  logic          w_wr;
  logic [AW-1:0] w_idx;
  logic          w_inwin;
  logic [63:0]   w_data;
  logic          w_mem_we;
  logic          w_unused;

  // Window decode: addresses below the base wrap to a large offset.
  assign w_off       = addr[19:0] - BASE_ADDR;
  assign w_inwin_now = (w_off < 20'(DEPTH));
  assign w_unused    = ^addr[62:20];

  assign w_accept  = (r_state == S_IDLE) && en;
  // Completion fires on the edge that enters DONE; abort (en low) wins over it.
  assign w_go_done = ((r_state == S_WAIT) && en && (r_wcnt == 4'd1)) ||
                     (w_accept && ZERO_WAIT);

  // With zero wait states the request completes on the accept edge, so the
  // live bus fields are used instead of the (not yet loaded) latches.
  assign w_wr    = w_accept ? addr[63]        : r_wr;
  assign w_idx   = w_accept ? w_off[AW-1:0]   : r_idx;
  assign w_inwin = w_accept ? w_inwin_now     : r_inwin;
  assign w_data  = w_accept ? SbusIn          : r_data;

  // Breset gating keeps a write from slipping in while reset is held.
  assign w_mem_we = Breset && w_go_done && w_wr && w_inwin;

  // Word memory, deliberately not reset.
  always_ff @(posedge sysClk) begin
    if (w_mem_we) r_mem[w_idx] <= w_data;
  end

  // Transaction FSM with registered Tdone/err/dbus_out.
  always_ff @(posedge sysClk or negedge Breset) begin
    if (!Breset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_inwin <= 1'b0;
      r_data  <= 64'h0;
      r_tdone <= 1'b0;
      r_err   <= 1'b0;
      r_dbus  <= 64'h0;
    end else begin
      r_tdone <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_wr    <= addr[63];
            r_idx   <= w_off[AW-1:0];
            r_inwin <= w_inwin_now;
            r_data  <= SbusIn;
            r_wcnt  <= 4'(WAIT_CYC);
            r_state <= ZERO_WAIT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!en) begin
            r_wcnt  <= 4'd0;
            r_state <= S_IDLE;
          end else if (r_wcnt == 4'd1) begin
            r_wcnt  <= 4'd0;
            r_state <= S_DONE;
          end else begin
            r_wcnt  <= r_wcnt - 4'd1;
          end
        end
        S_DONE: r_state <= S_HOLD;
        S_HOLD: if (!en) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_go_done) begin
        r_tdone <= 1'b1;
        r_err   <= !w_inwin;
        if (!w_wr) r_dbus <= w_inwin ? r_mem[w_idx] : ERR_DATA;
      end
    end
  end

  assign Tdone    = r_tdone;
  assign err      = r_err;
  assign dbus_out = r_dbus;

endmodule
